// File: rtl/sram_pkg.sv
// Shared types and constants for the external SRAM arbiter and its helpers.
package sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_HOLD
   } arb_state_t;

   localparam int PORT_CPU        = 0;
   localparam int PORT_LD         = 1;
   localparam int DEF_WAIT_CYCLES = 2;
   localparam int SRAM_AW         = 20;
   localparam int SRAM_DW         = 16;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the
// port that was not served last. Purely combinational, one-hot result.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] win_o
);

   assign win_o[0] = req_i[0] & (~req_i[1] |  last_i);
   assign win_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and setup/access/hold sequencer for the 1Mx16 external SRAM.
// Strobes are decoded from registered state only, so reset releases them at once.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int AW          = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_i,
   input  logic [1:0]           we_i,
   input  logic [AW-1:0]        addr0_i,
   input  logic [AW-1:0]        addr1_i,
   input  logic [SRAM_DW-1:0]   wdata0_i,
   input  logic [SRAM_DW-1:0]   wdata1_i,
   output logic [1:0]           gnt_o,
   output logic [1:0]           done_o,
   output logic [SRAM_DW-1:0]   rdata_o,
   output logic                 ce_n_o,
   output logic                 oe_n_o,
   output logic                 we_n_o,
   output logic                 ub_n_o,
   output logic                 lb_n_o,
   output logic [SRAM_AW-1:0]   addr_o,
   output logic [SRAM_DW-1:0]   sram_wdata_o,
   input  logic [SRAM_DW-1:0]   sram_rdata_i,
   output logic                 sram_oe_o
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

   arb_state_t          state_q, state_d;
   logic                port_q, port_d;
   logic                we_q, we_d;
   logic                last_q, last_d;
   logic [SRAM_AW-1:0]  addr_q, addr_d;
   logic [SRAM_DW-1:0]  wdata_q, wdata_d;
   logic [SRAM_DW-1:0]  rdata_q, rdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [1:0]          win;
   logic                active;

   rr_pick2 u_pick (
      .req_i  (req_i),
      .last_i (last_q),
      .win_o  (win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      we_d    = we_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|win) begin
               state_d = ST_SETUP;
               port_d  = win[PORT_LD];
               we_d    = we_i[win[PORT_LD]];
               addr_d  = SRAM_AW'(win[PORT_LD] ? addr1_i : addr0_i);
               wdata_d = win[PORT_LD] ? wdata1_i : wdata0_i;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = CNT_LOAD;
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               // Read data is sampled at the close of the final OE-low cycle.
               if (!we_q) begin
                  rdata_d = sram_rdata_i;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
            last_d  = port_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign active = (state_q != ST_IDLE);

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign gnt_o[gi]  = active & (port_q == 1'(gi));
      assign done_o[gi] = (state_q == ST_HOLD) & (port_q == 1'(gi));
   end

   assign ce_n_o       = ~active;
   assign ub_n_o       = ~active;
   assign lb_n_o       = ~active;
   assign oe_n_o       = ~((state_q == ST_ACCESS) & ~we_q);
   assign we_n_o       = ~((state_q == ST_ACCESS) &  we_q);
   assign sram_oe_o    = active & we_q;
   assign addr_o       = addr_q;
   assign sram_wdata_o = wdata_q;
   assign rdata_o      = rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the single external 1Mx16 SRAM. It sits between the SRAM pins and two requesters: the CPU memory interface (port 0) and a program loader/debug port (port 1). It grants one requester at a time with round-robin fairness and drives SRAM control strobes through a fixed setup/access/hold sequence. The CPU side no longer owns CE/OE/WE directly.

## Interface
- WAIT_CYCLES, default 2: number of cycles the OE or WE strobe is held low (≥1).
- AW, default 16: requester address width; zero-extended to the 20-bit SRAM address.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- req[1:0]  in  2  per-port request; held high until that port's done.
- we[1:0]  in  2  per-port write enable (1 = write, 0 = read); sampled at grant.
- addr0, addr1  in  AW  per-port word address; sampled at grant.
- wdata0, wdata1  in  16  per-port write data; sampled at grant.
- gnt[1:0]  out  2  one-hot; high for the whole transaction of the served port.
- done[1:0]  out  2  one-cycle pulse marking the end of the served transaction.
- rdata  out  16  read data; valid in the done cycle and held until the next read completes.
- CE, OE, WE, UB, LB  out  1  SRAM strobes, active-low.
- ADDR  out  20  SRAM address, {4'b0, latched addr}.
- sram_wdata  out  16  data to the tristate buffer.
- sram_rdata  in  16  data from the tristate buffer.
- sram_oe  out  1  tristate drive enable; high only while writing.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if any req is set, choose a port. A single requester wins outright. If both request, the winner is the port not served last (pointer `last`). Latch the port, we, addr and wdata, assert that gnt bit, and go to SETUP.
- SETUP (1 cycle): CE=0, ADDR valid. On a write, sram_oe=1.
- ACCESS (WAIT_CYCLES cycles, down-counter): CE=0. On a read, OE=0. On a write, WE=0 and sram_oe=1. On the last ACCESS cycle of a read, capture sram_rdata into rdata.
- HOLD (1 cycle): CE=0, OE=1, WE=1. On a write, sram_oe stays 1 for hold time. Pulse done for the served port, update `last` to the served port, go to IDLE.
- gnt clears on the same edge that leaves HOLD.
- UB=LB=0 whenever CE=0; otherwise 1.
- A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
- A req held high after done is treated as a new request in IDLE. Round-robin still applies, so a persistent requester cannot starve the other.
- Write and read from the same port back-to-back need no special handling; each is a separate transaction.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE, gnt=0, done=0;
  - CE=OE=WE=UB=LB=1, sram_oe=0;
  - ADDR=0, rdata=0, counter=0;
  - last=1, so port 0 wins the first contention.
- A reset asserted mid-write deasserts WE immediately (asynchronously). The partial write is abandoned and not retried.
- Latency from req sampled in IDLE to done is WAIT_CYCLES+2 cycles (SETUP + ACCESS + HOLD). The grant edge is cycle 0.
- Minimum spacing between consecutive transactions is WAIT_CYCLES+3 cycles, because IDLE costs one cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from req to the SRAM strobes.
- OE and WE are never low in the same cycle. sram_oe is never 1 while OE=0.

## Structure
- Shared package `sram_pkg`:
  - state enum `arb_state_t`;
  - port index constants PORT_CPU=0, PORT_LD=1;
  - default WAIT_CYCLES.
- One sub-module, `rr_pick2`: combinational two-input round-robin selector with inputs req and last, output the one-hot winner. It is reusable for other shared resources.
- The top level holds the FSM, the wait counter, the latched transaction registers and the strobe decode.

## Test plan
- Reset then port 0 read of addr 0x0005 (WAIT_CYCLES=2), with the SRAM model returning 0xBEEF. Required:
  - gnt[0] for 4 cycles;
  - OE low exactly 2 cycles;
  - ADDR=0x00005;
  - done[0] on cycle 3;
  - rdata=0xBEEF.
- Port 1 writes 0x1234 to 0xFFFF. Required:
  - WE low 2 cycles, OE never low;
  - sram_oe high from SETUP through HOLD;
  - sram_wdata=0x1234;
  - ADDR=0x0FFFF.
- Both req asserted from reset and held. Required: grants alternate 0,1,0,1 and every done is followed by the other port's gnt after one IDLE cycle.
- Port 0 drops req during ACCESS. Required: the transaction completes, done[0] pulses, and the FSM returns to IDLE.
- Reset asserted during an ACCESS write. Required: WE, CE and the other strobes go to 1 and sram_oe goes to 0 in the same cycle without a clock edge; after reset release the next contention grants port 0.
- WAIT_CYCLES=1 build, port 0 read then port 0 write. Required: each transaction lasts 3 cycles, and the cycles are spaced 4 apart.
